// File: rtl/n64_joybus_bit_decoder.sv
// n64_joybus_bit_decoder: oversampling Joybus bit decoder; each bit is held until the next fall, so the stop bit is dropped.
// Optional pulse-error detection and frame abort when N64_RX_ERR_EN is defined.
module n64_joybus_bit_decoder #(
    parameter int THRESH_CYCLES  = 32,
    parameter int IDLE_CYCLES    = 80,
    parameter int MIN_LOW_CYCLES = 4,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_rx,
    output logic       bit_valid,
    output logic       bit_data,
    output logic       busy,
    output logic       frame_end,
    output logic [6:0] frame_bits,
    output logic       err
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH, WAIT_HIGH} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THRESH  = CNT_W'(THRESH_CYCLES);
    localparam logic [CNT_W-1:0] IDLE_C  = CNT_W'(IDLE_CYCLES);

    if ((2 ** CNT_W) - 1 <= IDLE_CYCLES || MIN_LOW_CYCLES < 1) begin : g_bad_cfg
        $error("n64_joybus_bit_decoder: CNT_W too small for IDLE_CYCLES or bad MIN_LOW_CYCLES");
    end

    state_t           state_q, state_d;
    logic [1:0]       sync_q, sync_d;
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] low_cnt_q, low_cnt_d, high_cnt_q, high_cnt_d;
    logic             pend_bit_q, pend_bit_d, pend_vld_q, pend_vld_d;
    logic             bit_valid_q, bit_valid_d, bit_data_q, bit_data_d;
    logic             busy_q, busy_d, frame_end_q, frame_end_d;
    logic [6:0]       frame_bits_q, frame_bits_d;
    logic             cur, fall, rise;
`ifdef N64_RX_ERR_EN
    localparam logic [CNT_W-1:0] MIN_LOW = CNT_W'(MIN_LOW_CYCLES);
    logic err_q, err_d;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign cur  = sync_q[1];
    assign fall = prev_q & ~cur;
    assign rise = ~prev_q & cur;

    always_comb begin
        sync_d       = {sync_q[0], data_rx};
        prev_d       = cur;
        state_d      = state_q;
        low_cnt_d    = (low_cnt_q == CNT_MAX) ? low_cnt_q : low_cnt_q + 1'b1;
        high_cnt_d   = (high_cnt_q == CNT_MAX) ? high_cnt_q : high_cnt_q + 1'b1;
        pend_bit_d   = pend_bit_q;
        pend_vld_d   = pend_vld_q;
        frame_bits_d = frame_bits_q;
        bit_valid_d  = 1'b0;
        bit_data_d   = 1'b0;
        frame_end_d  = 1'b0;
`ifdef N64_RX_ERR_EN
        err_d        = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (fall) begin
                    low_cnt_d    = CNT_W'(1);
                    frame_bits_d = '0;
                    state_d      = LOW;
                end
            end
            LOW: begin
`ifdef N64_RX_ERR_EN
                if (low_cnt_q == IDLE_C) begin
                    err_d      = 1'b1;
                    pend_vld_d = 1'b0;
                    state_d    = WAIT_HIGH;
                end else if (rise && low_cnt_q < MIN_LOW) begin
                    err_d      = 1'b1;
                    pend_vld_d = 1'b0;
                    state_d    = IDLE;
                end else
`endif
                if (rise) begin
                    pend_bit_d = low_cnt_q < THRESH;
                    pend_vld_d = 1'b1;
                    high_cnt_d = CNT_W'(1);
                    state_d    = HIGH;
                end
            end
            HIGH: begin
                if (fall && pend_vld_q) begin
                    bit_valid_d  = 1'b1;
                    bit_data_d   = pend_bit_q;
                    pend_vld_d   = 1'b0;
                    frame_bits_d = (frame_bits_q == 7'd127) ? frame_bits_q : frame_bits_q + 7'd1;
                    low_cnt_d    = CNT_W'(1);
                    state_d      = LOW;
                end else if (high_cnt_q == IDLE_C) begin
                    // The bit still pending here is the stop bit.
                    frame_end_d = 1'b1;
                    pend_vld_d  = 1'b0;
                    state_d     = IDLE;
                end
            end
`ifdef N64_RX_ERR_EN
            WAIT_HIGH: state_d = cur ? IDLE : WAIT_HIGH;
`endif
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == LOW) || (state_d == HIGH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            sync_q       <= 2'b11;
            prev_q       <= 1'b1;
            low_cnt_q    <= '0;
            high_cnt_q   <= '0;
            pend_bit_q   <= 1'b0;
            pend_vld_q   <= 1'b0;
            frame_bits_q <= '0;
            bit_valid_q  <= 1'b0;
            bit_data_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_end_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            prev_q       <= prev_d;
            low_cnt_q    <= low_cnt_d;
            high_cnt_q   <= high_cnt_d;
            pend_bit_q   <= pend_bit_d;
            pend_vld_q   <= pend_vld_d;
            frame_bits_q <= frame_bits_d;
            bit_valid_q  <= bit_valid_d;
            bit_data_q   <= bit_data_d;
            busy_q       <= busy_d;
            frame_end_q  <= frame_end_d;
        end
    end

`ifdef N64_RX_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else err_q <= err_d;
    end
`endif

    assign bit_valid  = bit_valid_q;
    assign bit_data   = bit_data_q;
    assign busy       = busy_q;
    assign frame_end  = frame_end_q;
    assign frame_bits = frame_bits_q;
endmodule

// File: tb/tb_n64_joybus_bit_decoder.sv
// tb_n64_joybus_bit_decoder: frame table plus corner sequences; expected bits/counts queued on send, popped by a monitor.
module tb_n64_joybus_bit_decoder;
    logic       clk = 1'b0, reset = 1'b0, data_rx = 1'b1;
    logic       bit_valid, bit_data, busy, frame_end, err, bv_prev = 1'b0;
    logic [6:0] frame_bits;
    int         checks = 0, errors = 0;
    logic       exp_bits[$];
    int         exp_fb[$];

    typedef struct {
        logic [7:0] v;
        int         n;
    } frame_t;
    frame_t tbl[6];

    n64_joybus_bit_decoder dut (
        .clk(clk), .reset(reset), .data_rx(data_rx), .bit_valid(bit_valid), .bit_data(bit_data),
        .busy(busy), .frame_end(frame_end), .frame_bits(frame_bits), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse(input int lo, input int hi);
        @(negedge clk) data_rx = 1'b0;
        repeat (lo) @(negedge clk);
        data_rx = 1'b1;
        repeat (hi - 1) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        exp_bits.push_back(b);
        if (b) pulse(16, 48);
        else pulse(48, 16);
    endtask

    task automatic send_stop(input int fb);
        exp_fb.push_back(fb);
        pulse(16, 130);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bit_valid && frame_end) chk("bv_fe_overlap", 1, 0);
            if (bit_valid && bv_prev) chk("bv_spacing", 1, 0);
            if (bit_valid) begin
                if (exp_bits.size() == 0) chk("unexpected_bit", 1, 0);
                else chk("bit_data", bit_data, exp_bits.pop_front());
            end
            if (frame_end) begin
                if (exp_fb.size() == 0) chk("unexpected_frame_end", 1, 0);
                else chk("frame_bits", frame_bits, exp_fb.pop_front());
            end
            if (err !== 1'b0) chk("err", err, 0);
        end
        bv_prev <= bit_valid;
    end

    initial begin
        int k, bc;
        tbl[0] = '{8'h00, 8};
        tbl[1] = '{8'h03, 8};
        tbl[2] = '{8'hA5, 8};
        tbl[3] = '{8'hFF, 8};
        tbl[4] = '{8'h80, 1};
        tbl[5] = '{8'h40, 2};
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_bit_valid", bit_valid, 0);
        chk("rst_bit_data", bit_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_end", frame_end, 0);
        chk("rst_frame_bits", frame_bits, 0);
        chk("rst_err", err, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            for (int b = 0; b < tbl[i].n; b++) send_bit(tbl[i].v[7-b]);
            send_stop(tbl[i].n);
        end

        exp_bits.push_back(1'b1);
        pulse(31, 16);
        exp_bits.push_back(1'b0);
        pulse(32, 16);
        send_stop(2);

        exp_bits.push_back(1'b0);
        pulse(300, 16);
        send_stop(1);

        for (int i = 0; i < 130; i++) begin
            exp_bits.push_back(1'b1);
            pulse(8, 8);
        end
        send_stop(127);

        exp_fb.push_back(0);
        bc = 0;
        k = 0;
        @(negedge clk) data_rx = 1'b0;
        repeat (16) begin
            @(negedge clk);
            bc += int'(busy);
        end
        data_rx = 1'b1;
        while (!frame_end && k < 200) begin
            @(negedge clk);
            k++;
            bc += int'(busy);
        end
        chk("frame_end_latency", k, 83);
        chk("busy_cycles", bc, 96);
        repeat (20) @(negedge clk);

        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge clk) data_rx = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_mid_bit_valid", bit_valid, 0);
        chk("rst_mid_frame_end", frame_end, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_bits_left", exp_bits.size(), 0);
        @(negedge clk) data_rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (200) @(negedge clk);

        for (int b = 0; b < 8; b++) send_bit(b == 7);
        send_stop(8);

        repeat (10) @(negedge clk);
        chk("bits_left", exp_bits.size(), 0);
        chk("frames_left", exp_fb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
